// File: rtl/sampler_dma_voice_reader_pkg.sv
// sampler_dma_pkg: shared types and constants for the per-voice DMA reader.
//   - dma_state_t   : reader FSM states
//   - CTRL_* / STAT_*: bit positions in dma_control / dma_status
//   - AXI_*         : AXI4 encodings used on the read channel
package sampler_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } dma_state_t;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_LEN_LSB = 8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERROR   = 2;
  localparam int STAT_STOPPED = 3;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

endpackage

// File: rtl/sampler_dma_voice_reader_if.sv
// sampler_dma_voice_reader_if: AXI4 read channels plus the sample stream of
// one voice reader.
//   master : the reader (drives AR, rready, sample_data/sample_valid)
//   slave  : memory + mixer side (drives arready, R channel, sample_ready)
interface sampler_dma_voice_reader_if;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output sample_data, sample_valid,
    input  sample_ready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  sample_data, sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/sampler_dma_voice_reader_burst_calc.sv
// sampler_dma_burst_calc: combinational beat count for the next AR burst.
//   addr      : low 12 bits of the next word address (page offset)
//   remaining : words still to fetch
//   beats     : min(remaining, MAX_BURST_LEN, words left in the 4 KB page)
module sampler_dma_burst_calc #(
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_BITS      = 24
) (
  input  logic [11:0]         addr,
  input  logic [LEN_BITS-1:0] remaining,
  output logic [8:0]          beats
);

  logic [12:0] to_4k;
  logic [31:0] cap;

  always_comb begin
    // 4096 needs 13 bits, so an address at offset 0 yields a full 1024-word page
    to_4k = (13'd4096 - {1'b0, addr}) >> 2;
    cap   = 32'(MAX_BURST_LEN);
    if (32'(to_4k) < cap)     cap = 32'(to_4k);
    if (32'(remaining) < cap) cap = 32'(remaining);
    beats = 9'(cap);
  end

endmodule

// File: rtl/sampler_dma_voice_reader.sv
// sampler_dma_voice_reader: per-voice AXI4 read DMA feeding the voice mixer.
//   axi_clk/axi_reset : clock, synchronous active-high reset
//   dma_control       : [0] START (rising edge), [1] STOP, [31:8] length (words)
//   dma_base_addr     : start byte address, [1:0] ignored
//   dma_status        : [0] BUSY [1] DONE [2] ERROR [3] STOPPED, [31:8] words left
//   dma_curr_addr     : byte address of the next word to go out on the stream
//   bus               : AXI AR/R master + sample stream (R passes straight through)
module sampler_dma_voice_reader
  import sampler_dma_pkg::*;
#(
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_BITS      = 24
) (
  input  logic        axi_clk,
  input  logic        axi_reset,
  input  logic [31:0] dma_control,
  input  logic [31:0] dma_base_addr,
  output logic [31:0] dma_status,
  output logic [31:0] dma_curr_addr,
  sampler_dma_voice_reader_if.master bus
);

  dma_state_t          state, state_n;
  logic                start_q, start_edge, stop_req;
  logic [LEN_BITS-1:0] len_in, remaining, rem_next;
  logic [31:0]         curr_addr;
  logic [8:0]          beats, burst_beats, beat_cnt;
  logic                done_f, error_f, stopped_f, err_pend;
  logic                beat_acc, beat_err, err_now, last_expected;
  logic                unused_ok;

  assign unused_ok  = ^{dma_control[7:2], dma_base_addr[1:0]};

  assign start_edge = dma_control[CTRL_START] & ~start_q;
  assign stop_req   = dma_control[CTRL_STOP];
  assign len_in     = LEN_BITS'(dma_control[31:CTRL_LEN_LSB]);

  sampler_dma_burst_calc #(
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .LEN_BITS      (LEN_BITS)
  ) u_burst_calc (
    .addr      (curr_addr[11:0]),
    .remaining (remaining),
    .beats     (beats)
  );

  // R channel is a zero-latency pass-through; the mixer's ready is our rready
  assign beat_acc      = (state == ST_DATA) & bus.m_axi_rvalid & bus.sample_ready;
  assign last_expected = (beat_cnt == burst_beats - 9'd1);
  // a bad response, or rlast not on the beat we asked for, poisons the transfer
  assign beat_err      = (bus.m_axi_rresp != AXI_RESP_OKAY) | (bus.m_axi_rlast != last_expected);
  assign err_now       = err_pend | beat_err;
  // saturate so an over-long burst cannot wrap the count
  assign rem_next      = (remaining != '0) ? remaining - LEN_BITS'(1) : '0;

  assign bus.m_axi_arsize  = AXI_SIZE_4B;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arvalid = (state == ST_ADDR);
  // curr_addr and remaining are frozen in ADDR, so AR stays stable until arready
  assign bus.m_axi_araddr  = (state == ST_ADDR) ? curr_addr : '0;
  assign bus.m_axi_arlen   = (state == ST_ADDR) ? 8'(beats - 9'd1) : '0;
  assign bus.m_axi_rready  = (state == ST_DATA) & bus.sample_ready;
  assign bus.sample_valid  = (state == ST_DATA) & bus.m_axi_rvalid;
  assign bus.sample_data   = (state == ST_DATA) ? bus.m_axi_rdata : '0;

  assign dma_curr_addr = curr_addr;

  always_comb begin
    dma_status               = '0;
    dma_status[STAT_BUSY]    = (state != ST_IDLE);
    dma_status[STAT_DONE]    = done_f;
    dma_status[STAT_ERROR]   = error_f;
    dma_status[STAT_STOPPED] = stopped_f;
    dma_status[31:8]         = 24'(remaining);
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) state <= ST_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start_edge && len_in != '0) state_n = ST_ADDR;
      ST_ADDR: if (bus.m_axi_arready) state_n = ST_DATA;
      ST_DATA: if (beat_acc && bus.m_axi_rlast) begin
        if (err_now || rem_next == '0 || stop_req) state_n = ST_IDLE;
        else                                       state_n = ST_ADDR;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      start_q     <= 1'b0;
      curr_addr   <= '0;
      remaining   <= '0;
      burst_beats <= '0;
      beat_cnt    <= '0;
      done_f      <= 1'b0;
      error_f     <= 1'b0;
      stopped_f   <= 1'b0;
      err_pend    <= 1'b0;
    end else begin
      start_q <= dma_control[CTRL_START];
      case (state)
        ST_IDLE: if (start_edge) begin
          curr_addr <= {dma_base_addr[31:2], 2'b00};
          remaining <= len_in;
          done_f    <= (len_in == '0);
          error_f   <= 1'b0;
          stopped_f <= 1'b0;
          err_pend  <= 1'b0;
        end
        ST_ADDR: if (bus.m_axi_arready) begin
          burst_beats <= beats;
          beat_cnt    <= '0;
        end
        ST_DATA: if (beat_acc) begin
          curr_addr <= curr_addr + 32'd4;
          remaining <= rem_next;
          beat_cnt  <= beat_cnt + 9'd1;
          if (beat_err) err_pend <= 1'b1;
          if (bus.m_axi_rlast) begin
            if (err_now)              error_f   <= 1'b1;
            else if (rem_next == '0)  done_f    <= 1'b1;
            else if (stop_req)        stopped_f <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
